commit_ret_landing_checker: RTL

Commit-stage return-edge CFI checker, the return-side counterpart of the call/nop checker. It keeps a shadow stack of return addresses, pushed on every committed call. On every committed `ret` it requires that the next committed instruction is the landing nop (`addi x0,x0,imm`, imm[1:0]=2'h2) at exactly the popped return address. On violation it raises an ILLEGAL_INSTR exception and a stretched `cfi_signal_o` toward the PC/controller.

---
 rtl/commit_ret_landing_checker_pkg.sv | 55 +++++
 rtl/commit_ret_landing_checker_if.sv | 12 +
 rtl/commit_ret_landing_checker_shadow_stack.sv | 120 ++++++++++++
 rtl/commit_ret_landing_checker.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/commit_ret_landing_checker_pkg.sv
// Shared types and classification helpers for the commit-stage CFI checkers.
// Call and return checkers both use the same instruction predicates from here.
package commit_ret_landing_checker_pkg;

  localparam int VLEN = 64;
  localparam int XLEN = 64;

  localparam logic [1:0] NOP_IMM_CALL = 2'h1;
  localparam logic [1:0] NOP_IMM_RET  = 2'h2;

  localparam logic [XLEN-1:0] ILLEGAL_INSTR = 64'd2;

  typedef enum logic [3:0] {
    ADD, SUB, ANDL, ORL, LD, SD, JAL, JALR, BEQ, CSR_OP
  } fu_op_t;

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic            valid;
  } exception_t;

  typedef struct packed {
    logic [VLEN-1:0] pc;
    fu_op_t          op;
    logic [4:0]      rs1;
    logic [4:0]      rd;
    logic [XLEN-1:0] result;
    logic            is_compressed;
    exception_t      ex;
  } scoreboard_entry_t;

  typedef enum logic {
    IDLE,
    WAIT_LAND
  } ret_state_t;

  function automatic logic is_call(scoreboard_entry_t e);
    return ((e.op == JAL) || (e.op == JALR)) && (e.rd == 5'd1);
  endfunction

  function automatic logic is_ret(scoreboard_entry_t e);
    return (e.op == JALR) && (e.rd == 5'd0) && (e.rs1 == 5'd1);
  endfunction

  // The landing nop is addi x0,x0,imm; its immediate surfaces in result.
  function automatic logic is_landing(scoreboard_entry_t e, logic [1:0] imm);
    return (e.op == ADD) && (e.rd == 5'd0) && (e.rs1 == 5'd0) && (e.result[1:0] == imm);
  endfunction

  function automatic logic [VLEN-1:0] link_addr(scoreboard_entry_t e);
    return e.pc + (e.is_compressed ? VLEN'(2) : VLEN'(4));
  endfunction

endpackage

// File: rtl/commit_ret_landing_checker_if.sv
// Commit bus from the scoreboard: per-port ack strobe plus the retiring entry.
interface commit_ret_landing_checker_if #(
  parameter int NR_COMMIT_PORTS = 2
) ();
  import commit_ret_landing_checker_pkg::*;

  logic [NR_COMMIT_PORTS-1:0] commit_ack;
  scoreboard_entry_t          commit_instr [NR_COMMIT_PORTS];

  modport master (output commit_ack, output commit_instr);
  modport slave  (input  commit_ack, input  commit_instr);
endinterface

// File: rtl/commit_ret_landing_checker_shadow_stack.sv
// Circular return-address LIFO; on overflow the oldest entry is overwritten
// and counted in lost so later underflowing returns can still be tolerated.
module cfi_shadow_stack #(
  parameter int DEPTH   = 16,
  parameter int WIDTH   = 64,
  parameter int NR_PUSH = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           clr_i,
  input  logic [NR_PUSH-1:0]             push_i,
  input  logic [NR_PUSH-1:0][WIDTH-1:0]  data_i,
  input  logic                           pop_i,
  output logic [WIDTH-1:0]               data_o,
  output logic                           empty_o,
  output logic                           full_o,
  output logic                           lost_o,
  output logic                           ovf_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] ptr_reg, ptr_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [CW-1:0] lost_reg, lost_next;
  logic          ovf_reg, ovf_next;

  logic [NR_PUSH-1:0]         eff_push;
  logic [NR_PUSH-1:0]         wr_en;
  logic [NR_PUSH-1:0][AW-1:0] wr_addr;
  logic                       cancel_done;
  logic                       pop_only;
  logic [WIDTH-1:0]           mem [DEPTH];

  always_comb begin
    ptr_next    = ptr_reg;
    cnt_next    = cnt_reg;
    lost_next   = lost_reg;
    ovf_next    = ovf_reg;
    wr_en       = '0;
    wr_addr     = '0;
    eff_push    = push_i;
    cancel_done = 1'b0;
    // A pop in the same cycle as a push consumes that push directly; the
    // caller supplies the bypassed address, so the stack is left untouched.
    for (int k = NR_PUSH - 1; k >= 0; k--) begin
      if (pop_i && push_i[k] && !cancel_done) begin
        eff_push[k] = 1'b0;
        cancel_done = 1'b1;
      end
    end
    pop_only = pop_i && !cancel_done;

    for (int k = 0; k < NR_PUSH; k++) begin
      if (eff_push[k]) begin
        wr_en[k]   = 1'b1;
        wr_addr[k] = ptr_next;
        ptr_next   = ptr_next + AW'(1);
        if (cnt_next == CW'(DEPTH)) begin
          if (lost_next != CW'(DEPTH)) lost_next = lost_next + CW'(1);
          ovf_next = 1'b1;
        end else begin
          cnt_next = cnt_next + CW'(1);
        end
      end
    end

    if (pop_only) begin
      if (cnt_reg != '0) begin
        ptr_next = ptr_reg - AW'(1);
        cnt_next = cnt_reg - CW'(1);
      end else if (lost_reg != '0) begin
        lost_next = lost_reg - CW'(1);
      end
    end

    if (clr_i) begin
      ptr_next  = '0;
      cnt_next  = '0;
      lost_next = '0;
      ovf_next  = 1'b0;
      wr_en     = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_reg  <= '0;
      cnt_reg  <= '0;
      lost_reg <= '0;
      ovf_reg  <= 1'b0;
    end else begin
      ptr_reg  <= ptr_next;
      cnt_reg  <= cnt_next;
      lost_reg <= lost_next;
      ovf_reg  <= ovf_next;
    end
  end

  genvar gi;
  for (gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [WIDTH-1:0] entry_reg;
    always_ff @(posedge clk_i) begin
      for (int k = 0; k < NR_PUSH; k++) begin
        if (wr_en[k] && (wr_addr[k] == AW'(gi))) entry_reg <= data_i[k];
      end
    end
    assign mem[gi] = entry_reg;
  end

  logic [AW-1:0] top_idx;
  assign top_idx = ptr_reg - AW'(1);
  assign data_o  = mem[top_idx];
  assign empty_o = (cnt_reg == '0);
  assign full_o  = (cnt_reg == CW'(DEPTH));
  assign lost_o  = (lost_reg != '0);
  assign ovf_o   = ovf_reg;

endmodule

// File: rtl/commit_ret_landing_checker.sv
// Return-edge CFI checker: every committed ret must be followed by the
// landing nop at the popped return address, else an ILLEGAL_INSTR is raised.
module commit_ret_landing_checker
  import commit_ret_landing_checker_pkg::*;
#(
  parameter int         DEPTH           = 16,
  parameter int         NR_COMMIT_PORTS = 2,
  parameter int         CFI_HOLD        = 11,
  parameter logic [1:0] NOP_IMM         = NOP_IMM_RET
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  input  logic                          csr_en_i,
  commit_ret_landing_checker_if.slave   commit_bus,
  output logic                          cfi_signal_o,
  output exception_t                    exception_o,
  output logic                          ovf_o
);

  localparam int HW = $clog2(CFI_HOLD + 1);

  logic [NR_COMMIT_PORTS-1:0]           qual, call_hit, ret_hit, land_hit;
  logic [NR_COMMIT_PORTS-1:0][VLEN-1:0] ret_addr;
  logic [NR_COMMIT_PORTS-1:0]           unused_bits;

  genvar gi;
  for (gi = 0; gi < NR_COMMIT_PORTS; gi++) begin : g_classify
    assign qual[gi]        = commit_bus.commit_ack[gi] && !commit_bus.commit_instr[gi].ex.valid;
    assign call_hit[gi]    = qual[gi] && is_call(commit_bus.commit_instr[gi]);
    assign ret_hit[gi]     = qual[gi] && is_ret(commit_bus.commit_instr[gi]);
    assign land_hit[gi]    = qual[gi] && is_landing(commit_bus.commit_instr[gi], NOP_IMM);
    assign ret_addr[gi]    = link_addr(commit_bus.commit_instr[gi]);
    assign unused_bits[gi] = ^{commit_bus.commit_instr[gi].ex.cause,
                               commit_bus.commit_instr[gi].ex.tval,
                               commit_bus.commit_instr[gi].result[XLEN-1:2]};
  end

  ret_state_t                 state_reg, state_next;
  logic                       skip_reg, skip_next;
  logic [VLEN-1:0]            exp_pc_reg, exp_pc_next;
  logic [VLEN-1:0]            ret_pc_reg, ret_pc_next;
  logic [HW-1:0]              hold_reg, hold_next;
  exception_t                 exception_reg, exception_next;

  logic [NR_COMMIT_PORTS-1:0] push;
  logic                       pop;
  logic                       pushed;
  logic [VLEN-1:0]            pushed_addr;
  logic                       viol;
  logic [XLEN-1:0]            viol_tval;
  logic [VLEN-1:0]            stack_top;
  logic                       stack_empty, stack_full, stack_lost;

  cfi_shadow_stack #(
    .DEPTH   (DEPTH),
    .WIDTH   (VLEN),
    .NR_PUSH (NR_COMMIT_PORTS)
  ) i_stack (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (!csr_en_i),
    .push_i  (push),
    .data_i  (ret_addr),
    .pop_i   (pop),
    .data_o  (stack_top),
    .empty_o (stack_empty),
    .full_o  (stack_full),
    .lost_o  (stack_lost),
    .ovf_o   (ovf_o)
  );

  // Flush is irrelevant here: only instructions that actually committed are seen.
  logic unused_misc;
  assign unused_misc = ^{flush_i, stack_full, unused_bits};

  always_comb begin
    state_next  = state_reg;
    skip_next   = skip_reg;
    exp_pc_next = exp_pc_reg;
    ret_pc_next = ret_pc_reg;
    push        = '0;
    pop         = 1'b0;
    pushed      = 1'b0;
    pushed_addr = '0;
    viol        = 1'b0;
    viol_tval   = '0;
    for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
      if (qual[p]) begin
        if (state_next == WAIT_LAND) begin
          if (!(land_hit[p] && (skip_next || (commit_bus.commit_instr[p].pc == exp_pc_next)))) begin
            viol      = 1'b1;
            viol_tval = ret_pc_next;
          end
          state_next = IDLE;
        end else if (call_hit[p]) begin
          push[p]     = 1'b1;
          pushed      = 1'b1;
          pushed_addr = ret_addr[p];
        end else if (ret_hit[p]) begin
          ret_pc_next = commit_bus.commit_instr[p].pc;
          if (pushed || !stack_empty || stack_lost) begin
            pop         = 1'b1;
            skip_next   = !pushed && stack_empty;
            exp_pc_next = pushed ? pushed_addr : stack_top;
            state_next  = WAIT_LAND;
          end else begin
            viol      = 1'b1;
            viol_tval = commit_bus.commit_instr[p].pc;
          end
        end
      end
    end
    if (!csr_en_i) begin
      state_next = IDLE;
      skip_next  = 1'b0;
      push       = '0;
      pop        = 1'b0;
      viol       = 1'b0;
    end

    hold_next      = viol ? HW'(CFI_HOLD) : ((hold_reg != '0) ? hold_reg - HW'(1) : '0);
    exception_next = viol ? '{cause: ILLEGAL_INSTR, tval: viol_tval, valid: 1'b1} : '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg     <= IDLE;
      skip_reg      <= 1'b0;
      exp_pc_reg    <= '0;
      ret_pc_reg    <= '0;
      hold_reg      <= '0;
      exception_reg <= '0;
    end else begin
      state_reg     <= state_next;
      skip_reg      <= skip_next;
      exp_pc_reg    <= exp_pc_next;
      ret_pc_reg    <= ret_pc_next;
      hold_reg      <= hold_next;
      exception_reg <= exception_next;
    end
  end

  assign exception_o  = exception_reg;
  assign cfi_signal_o = (hold_reg != '0);

endmodule
